// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the HI/LO multiply/divide sequencer.
//   - R-type funct codes for MULT/MULTU/DIV/DIVU and MFHI/MTHI/MFLO/MTLO
//   - ALUOP_RTYPE: ALU op value under which the funct field is decoded
//   - muldiv_state_e: sequencer states
//   - DefaultWidth: default operand/HI/LO width
package muldiv_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMul   = 2'd1,
    StDiv   = 2'd2,
    StFixup = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   Multiply: if mq_i[0], add mcand_i to acc_i, then shift {acc, mq} right by one.
//   Divide:   shift {acc, mq} left by one, trial-subtract mcand_i from acc, keep the
//             difference and shift in a 1 when it does not go negative (restoring).
// Ports:
//   is_div_i  select divide step (1) or multiply step (0)
//   acc_i     partial product high half / partial remainder
//   mq_i      multiplier (low product half) / dividend-quotient shift register
//   mcand_i   multiplicand / divisor magnitude
//   acc_o     next acc
//   mq_o      next mq
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_bits;

  // The partial remainder is always below the divisor, so the shifted value never
  // needs its top bit for the result; only the sign of the trial difference matters.
  assign unused_bits = ^{shifted[WIDTH], diff[WIDTH]};

  always_comb begin
    sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, mcand_i} : '0);
    shifted = {acc_i, mq_i[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, mcand_i};
    acc_o   = sum[WIDTH:1];
    mq_o    = {sum[0], mq_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (!diff[WIDTH+1]) begin
        acc_o = diff[WIDTH-1:0];
        mq_o  = {mq_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        mq_o  = {mq_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: EX-stage multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies finish as soon as
// the remaining multiplier bits are all zero (divide timing is unaffected).
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   opValid               EX-stage instruction valid
//   ALUOpF                main-control ALU op; only R-type is decoded
//   functToMulDiv         instruction funct field
//   operandA, operandB    rs, rt values
//   hiOut, loOut          current HI/LO
//   busy                  operation in progress (accept through FIXUP)
//   stall                 combinational pipeline freeze for HI/LO-dependent ops
//   done                  one-cycle pulse after HI/LO update
//   divByZero             one-cycle pulse with done for a zero divisor
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             opValid,
  input  logic [1:0]       ALUOpF,
  input  logic [5:0]       functToMulDiv,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             divByZero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  muldiv_state_e    state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             is_div_q, is_div_d, zero_div_q, zero_div_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  // Decode
  logic rtype, op_mul, op_div, op_signed, op_mthi, op_mtlo, op_mf, op_any;
  assign rtype     = opValid && (ALUOpF == ALUOP_RTYPE);
  assign op_mul    = rtype && (functToMulDiv == FUNCT_MULT || functToMulDiv == FUNCT_MULTU);
  assign op_div    = rtype && (functToMulDiv == FUNCT_DIV || functToMulDiv == FUNCT_DIVU);
  assign op_signed = functToMulDiv == FUNCT_MULT || functToMulDiv == FUNCT_DIV;
  assign op_mthi   = rtype && (functToMulDiv == FUNCT_MTHI);
  assign op_mtlo   = rtype && (functToMulDiv == FUNCT_MTLO);
  assign op_mf     = rtype && (functToMulDiv == FUNCT_MFHI || functToMulDiv == FUNCT_MFLO);
  assign op_any    = op_mul || op_div || op_mthi || op_mtlo || op_mf;

  // Operand magnitudes for the signed forms
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = op_signed && operandA[WIDTH-1];
  assign b_neg = op_signed && operandB[WIDTH-1];
  assign a_mag = a_neg ? -operandA : operandA;
  assign b_mag = b_neg ? -operandB : operandB;

  logic [WIDTH-1:0] step_acc, step_mq;
  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i(state_q == StDiv),
    .acc_i   (acc_q),
    .mq_i    (mq_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .mq_o    (step_mq)
  );

  // Right-alignment still owed to the product when a multiply leaves MUL early
  logic [CntW:0] fix_shift;
  logic          early_out;

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] done_bits, live_mask;
  logic [CntW:0]    shift_q;
  // Bits [cnt:0] of mq are the multiplier bits not yet consumed
  assign done_bits = {WIDTH{1'b1}} << cnt_q;
  assign live_mask = ~(done_bits << 1);
  assign early_out = (mq_q & live_mask) == '0;
  assign fix_shift = shift_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
    end else if (state_q == StIdle) begin
      shift_q <= '0;
    end else if (state_q == StMul && early_out) begin
      shift_q <= {1'b0, cnt_q} + (CntW+1)'(1);
    end
  end
`else
  assign early_out = 1'b0;
  assign fix_shift = '0;
`endif

  logic [2*WIDTH-1:0] prod_mag, prod_res;
  assign prod_mag = {acc_q, mq_q} >> fix_shift;
  assign prod_res = neg_lo_q ? -prod_mag : prod_mag;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    is_div_d   = is_div_q;
    zero_div_d = zero_div_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_mul || op_div) begin
          acc_d      = '0;
          cnt_d      = CntW'(WIDTH - 1);
          is_div_d   = op_div;
          neg_lo_d   = a_neg ^ b_neg;
          neg_hi_d   = op_div ? a_neg : (a_neg ^ b_neg);
          zero_div_d = op_div && (operandB == '0);
          // Divide keeps the dividend in mq; multiply keeps the multiplier there
          mq_d       = op_div ? a_mag : b_mag;
          mcand_d    = op_div ? b_mag : a_mag;
          if (op_div) begin
            state_d = (operandB == '0) ? StFixup : StDiv;
          end else begin
            state_d = StMul;
          end
        end else if (op_mthi) begin
          hi_d = operandA;
        end else if (op_mtlo) begin
          lo_d = operandA;
        end
      end
      StMul, StDiv: begin
        if (state_q == StMul && early_out) begin
          state_d = StFixup;
        end else begin
          acc_d = step_acc;
          mq_d  = step_mq;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_d = StFixup;
          end
        end
      end
      StFixup: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (zero_div_q) begin
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_lo_q ? -mq_q : mq_q;
          hi_d = neg_hi_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = prod_res;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      is_div_q   <= 1'b0;
      zero_div_q <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      mcand_q    <= mcand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      is_div_q   <= is_div_d;
      zero_div_q <= zero_div_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign hiOut     = hi_q;
  assign loOut     = lo_q;
  assign busy      = state_q != StIdle;
  assign stall     = op_any && (busy || state_q == StFixup);
  assign done      = done_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed, table-driven bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        opValid = 1'b0;
  logic [1:0]  ALUOpF = 2'b00;
  logic [5:0]  functToMulDiv = 6'd0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic [31:0] hiOut, loOut;
  logic        busy, stall, done, divByZero;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  muldiv_sequencer #(
    .WIDTH(32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opValid      (opValid),
    .ALUOpF       (ALUOpF),
    .functToMulDiv(functToMulDiv),
    .operandA     (operandA),
    .operandB     (operandB),
    .hiOut        (hiOut),
    .loOut        (loOut),
    .busy         (busy),
    .stall        (stall),
    .done         (done),
    .divByZero    (divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    opValid       = 1'b1;
    ALUOpF        = op;
    functToMulDiv = f;
    operandA      = a;
    operandB      = b;
  endtask

  // Present an R-type op for exactly one edge, then withdraw it
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    drive(ALUOP_RTYPE, f, a, b);
    tick();
    opValid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit stall_ok;

    vecs[0] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[1] = '{FUNCT_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[2] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3] = '{FUNCT_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[4] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5] = '{FUNCT_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 33};
    vecs[6] = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[7] = '{FUNCT_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 33};
    vecs[8] = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 33};
    vecs[9] = '{FUNCT_MULTU, 32'd5,        32'd0,        32'd0,        32'd0,        33};

    // Reset state
    #1;
    chk("rst_hi", hiOut, 0);
    chk("rst_lo", loOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", divByZero, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Table of multiply/divide results
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_done(lat);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_hi", i), hiOut, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), loOut, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i), divByZero, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
      if (vecs[i].f == FUNCT_DIV || vecs[i].f == FUNCT_DIVU || !EarlyOut)
        chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      tick();
      chk($sformatf("v%0d_done_once", i), done, 0);
    end

    // Divide by zero leaves HI/LO alone
    issue(FUNCT_MTHI, 32'h11111111, 32'd0);
    issue(FUNCT_MTLO, 32'h11111111, 32'd0);
    issue(FUNCT_DIV, 32'd5, 32'd0);
    chk("dbz_busy", busy, 1);
    chk("dbz_no_early_done", done, 0);
    tick();
    chk("dbz_done", done, 1);
    chk("dbz_flag", divByZero, 1);
    chk("dbz_busy_one_cycle", busy, 0);
    chk("dbz_hi", hiOut, 32'h11111111);
    chk("dbz_lo", loOut, 32'h11111111);
    tick();
    chk("dbz_flag_once", divByZero, 0);

    // MTHI then MFHI back-to-back, no stall
    drive(ALUOP_RTYPE, FUNCT_MTHI, 32'hA5A5A5A5, 32'd0);
    #1;
    chk("mthi_stall", stall, 0);
    tick();
    drive(ALUOP_RTYPE, FUNCT_MFHI, 32'd0, 32'd0);
    #1;
    chk("mfhi_stall", stall, 0);
    chk("mfhi_value", hiOut, 32'hA5A5A5A5);
    chk("mthi_lo_untouched", loOut, 32'h11111111);
    tick();
    opValid = 1'b0;

    // Non-R-type ALU op with a MULT or MTHI funct does nothing
    drive(2'b00, FUNCT_MULT, 32'd5, 32'd5);
    #1;
    chk("nonr_stall", stall, 0);
    tick();
    chk("nonr_busy", busy, 0);
    drive(2'b00, FUNCT_MTHI, 32'hDEADBEEF, 32'd0);
    repeat (3) tick();
    opValid = 1'b0;
    chk("nonr_done", done, 0);
    chk("nonr_hi", hiOut, 32'hA5A5A5A5);

    // MFLO five cycles after MULT stalls until done and reads the product
    issue(FUNCT_MULT, 32'd6, 32'd7);
    repeat (4) tick();
    drive(ALUOP_RTYPE, FUNCT_MFLO, 32'd0, 32'd0);
    #1;
    stall_ok = 1'b1;
    lat = 0;
    while (!done && lat < 100) begin
      if (!stall) stall_ok = 1'b0;
      tick();
      lat++;
    end
    chk("mflo_stall_held", stall_ok, 1);
    chk("mflo_done", done, 1);
    chk("mflo_release", stall, 0);
    chk("mflo_value", loOut, 32'd42);
    opValid = 1'b0;
    tick();

    // A second MULT while busy stalls and does not disturb the first
    issue(FUNCT_MULT, 32'd6, 32'd7);
    drive(ALUOP_RTYPE, FUNCT_MULTU, 32'd100, 32'd100);
    #1;
    chk("mult2_stall", stall, 1);
    wait_done(lat);
    opValid = 1'b0;
    chk("mult2_done", done, 1);
    chk("mult2_latency", lat, 33);
    chk("mult2_release", stall, 0);
    chk("mult2_hi", hiOut, 0);
    chk("mult2_lo", loOut, 32'd42);
    tick();
    chk("mult2_not_started", busy, 0);

    // Reset mid-operation clears HI/LO and busy immediately
    issue(FUNCT_MTHI, 32'h0BADF00D, 32'd0);
    issue(FUNCT_MULT, 32'd3, 32'd3);
    repeat (9) tick();
    chk("rst_mid_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_hi", hiOut, 0);
    chk("rst_mid_lo", loOut, 0);
    chk("rst_mid_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_mid_done", done, 0);

`ifdef MULDIV_EARLY_OUT_EN
    // Zero multiplier finishes at E0+2
    issue(FUNCT_MTHI, 32'h77777777, 32'd0);
    issue(FUNCT_MTLO, 32'h77777777, 32'd0);
    issue(FUNCT_MULTU, 32'd5, 32'd0);
    wait_done(lat);
    chk("early_latency", lat, 2);
    chk("early_hi", hiOut, 0);
    chk("early_lo", loOut, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the MIPS MULT/MULTU/DIV/DIVU instructions and the HI/LO register pair, sitting in the EX stage beside the ALU. It decodes the R-type funct field under the same ALUOpF qualification the ALU control uses, and runs an iterative shift-add multiply or restoring divide. It owns HI/LO and raises a stall to the pipeline while a HI/LO-dependent instruction must wait.

## Interface
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opValid  in  1  EX-stage instruction valid
- ALUOpF  in  2  main-control ALU op; only 2'b10 (R-type) is decoded
- functToMulDiv  in  6  instruction funct field
- operandA, operandB  in  WIDTH  rs, rt values
- hiOut, loOut  out  WIDTH  current HI/LO, read directly by MFHI/MFLO
- busy  out  1  iteration in progress
- stall  out  1  combinational; freeze IF/ID/EX this cycle
- done  out  1  one-cycle pulse after HI/LO update
- divByZero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with operandB==0

## Operation
- Decode when opValid && ALUOpF==2'b10:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
- States:
  - IDLE: accepts MULT/DIV. Operands are converted to magnitudes for the signed forms, result signs latched, counter=WIDTH-1, go to MUL or DIV.
  - MUL / DIV: one step per cycle, counter decrements; at counter==0 go to FIXUP.
  - FIXUP: apply sign correction, write HI/LO, go to IDLE, pulse done.
- Multiply: 2*WIDTH-bit product {HI,LO}.
- Divide: LO=quotient, HI=remainder; remainder takes the dividend's sign.
- Divide boundary cases:
  - -2^(WIDTH-1) / -1 yields LO=0x80000000, HI=0; no flag.
  - DIV/DIVU with operandB==0: IDLE goes straight to FIXUP. HI/LO are unchanged; done and divByZero pulse.
- MTHI/MTLO in IDLE write operandA at the next edge; the other register is untouched.
- stall = decoded (MULT/DIV/MFHI/MFLO/MTHI/MTLO) && (busy || state==FIXUP). A new MULT/DIV never aborts one in flight.
- Non-R-type or unlisted funct values: no effect.

## Timing
- Reset (asynchronous, immediate): state IDLE, hiOut=loOut=0, busy=0, stall=0, done=0, divByZero=0. Reset mid-operation discards the result.
- Accept at edge E0. busy is high from E0 until edge E0+WIDTH+1. HI/LO are updated at E0+WIDTH+1, and done is high for the cycle after that edge. For WIDTH=32 this is 33 cycles.
- Divide by zero: HI/LO unchanged; busy high for exactly one cycle; done and divByZero are high for the cycle after edge E0+1.
- An MFHI/MFLO stalled behind an operation releases in the cycle done is high and reads the new value.
- MTHI/MTLO: 1-cycle latency, no stall when IDLE.

## Configuration
- MULDIV_EARLY_OUT_EN:
  - Defined: in MUL, if all unprocessed multiplier bits are zero, go to FIXUP immediately. FIXUP applies the outstanding right-alignment shift.
  - Latency becomes data-dependent; for operandB==0 the result appears at E0+2.
  - Undefined: multiply always takes WIDTH+1 cycles.
  - Divide timing is identical either way.

## Structure
- Package muldiv_pkg holds:
  - funct localparams
  - ALUOP_RTYPE=2'b10
  - the state enum (IDLE, MUL, DIV, FIXUP)
  - WIDTH default
- Sub-module muldiv_step: combinational single iteration (conditional add-and-shift or trial-subtract-and-shift). The top level holds the FSM, counter, sign latches and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at E0+33; done pulses once.
- MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- MULT 6*7, then MFLO five cycles later -> stall held until done, read returns LO=42. A second MULT during busy -> stall high, first result intact.
- DIV 5/0 with HI=LO=0x11111111 -> divByZero and done pulse after E0+1; HI/LO still 0x11111111; busy high one cycle.
- MTHI 0xA5A5A5A5 then MFHI next cycle -> hiOut=0xA5A5A5A5, no stall. ALUOpF=2'b00 with funct 011000 -> no activity.
- reset_n low at cycle 10 of a MULT -> hiOut=loOut=0, busy=0 immediately. With MULDIV_EARLY_OUT_EN, MULTU 5*0 -> HI=LO=0 at E0+2.
